lsu_16: RTL and testbench
=========================

Name: lsu_16

Overview:
- Load/store unit of mycpu. Sits directly upstream of the 3-input 16-bit writeback mux.
- Takes one load or store request from the control unit and runs a single-outstanding req/ack transaction on the data-memory bus.
- Returns load data on ldata_out. ldata_out is the memory-data input of the writeback mux.
- Pulses done_out when finished. A bus timeout aborts the access and reports err_out.

Parameters:
- TIMEOUT, 15: maximum cycles in REQ waiting for mem_ack_in. Legal range is 1 to 255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start_in  in  1  request from control. Sampled only in IDLE.
- we_in  in  1  1 = store, 0 = load. Captured with start_in.
- addr_in  in  16  word address. Captured with start_in.
- wdata_in  in  16  store data. Captured with start_in.
- busy_out  out  1  high whenever state is not IDLE.
- done_out  out  1  one-cycle completion pulse.
- err_out  out  1  one-cycle pulse, coincident with done_out, on timeout.
- ldata_out  out  16  last load result. Held until the next load completes. Feeds the writeback mux.
- mem_req_out  out  1  bus request.
- mem_we_out  out  1  bus write enable.
- mem_addr_out  out  16  bus address.
- mem_wdata_out  out  16  bus write data.
- mem_ack_in  in  1  bus acknowledge. Meaningful only while mem_req_out = 1.
- mem_rdata_in  in  16  bus read data. Valid in the cycle mem_ack_in = 1.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - state goes to IDLE.
  - Counter, done_out, err_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out and ldata_out all go to 0.
  - Reset mid-transaction drops mem_req_out at that edge. There is no completion pulse.
- State machine. States are IDLE, REQ and DONE. All outputs are registered. busy_out is decoded from state.
- IDLE:
  - If start_in = 1, capture we_in, addr_in and wdata_in into mem_we_out, mem_addr_out and mem_wdata_out.
  - In the same edge, set mem_req_out = 1, clear the counter and go to REQ.
  - mem_ack_in is ignored in IDLE.
- REQ:
  - mem_req_out, mem_we_out, mem_addr_out and mem_wdata_out are held stable.
  - If mem_ack_in = 1:
    - Set mem_req_out = 0, done_out = 1, err_out = 0, and go to DONE.
    - If it is a load, ldata_out is loaded with mem_rdata_in.
    - If it is a store, ldata_out is unchanged.
  - Else if counter = TIMEOUT-1:
    - Set mem_req_out = 0, done_out = 1, err_out = 1, and go to DONE.
    - If it is a load, ldata_out is set to 16'h0000.
    - If it is a store, ldata_out is unchanged.
  - Otherwise the counter increments.
  - REQ therefore lasts at most TIMEOUT cycles.
  - An ack in the final counted cycle wins: it is a success, not a timeout.
- DONE:
  - Next edge clears done_out and err_out and goes to IDLE.
  - start_in is ignored in DONE. It must be re-asserted in IDLE to be accepted.
- Latency:
  - start_in is sampled at edge E0, and mem_req_out is high from E0.
  - If ack is present in the first REQ cycle, it is sampled at E1. done_out is then high from E1 to E2, and busy_out drops after E2.
  - Minimum start-to-done is 1 cycle. Back-to-back start acceptance is every 3 cycles.
- Protocol rules:
  - start_in while busy_out = 1 is dropped. It is not queued.
  - Acks outside REQ have no effect.
  - mem_rdata_in is sampled only on an ack edge in REQ.
- Counter width is 8 bits. The counter never wraps, because TIMEOUT is at most 255.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with start_in = 1 → all outputs 0, busy_out = 0. After release, start_in is accepted at the next edge.
- Load, immediate ack: addr 16'h0040, memory returns 16'hBEEF with ack in the first REQ cycle.
  - mem_req_out is high for exactly 1 cycle with mem_we_out = 0 and mem_addr_out = 16'h0040.
  - done_out pulses 1 cycle after acceptance, with ldata_out = 16'hBEEF and err_out = 0.
- Store, delayed ack: wdata 16'h1234, addr 16'h00FF, ack after 4 cycles.
  - Bus outputs are stable for 4 cycles. done_out pulses the cycle after the ack.
  - ldata_out keeps its previous value, 16'hBEEF.
- Timeout, TIMEOUT = 15: load with no ack.
  - mem_req_out is high for exactly 15 cycles.
  - done_out and err_out pulse together. ldata_out = 16'h0000.
  - A repeat with the ack in the 15th cycle gives err_out = 0 and the read data.
- Busy protocol: pulse start_in in REQ and again in DONE → both ignored, only one bus transaction. Ack asserted in IDLE → no effect.
- Reset mid-REQ: assert rst_n = 0 on the 3rd REQ cycle → mem_req_out = 0 at that edge, no done_out pulse, ldata_out = 0.

Source files
------------

// File: rtl/lsu_16_if.sv
// lsu_16_if: data-memory bus between the load/store unit and memory.
//   mem_req_out   - bus request (driven by the LSU)
//   mem_we_out    - 1 = write, 0 = read
//   mem_addr_out  - 16-bit word address
//   mem_wdata_out - 16-bit write data
//   mem_ack_in    - acknowledge from memory, meaningful only while requested
//   mem_rdata_in  - read data, valid in the acknowledge cycle
// master: the LSU side. slave: the memory side.
interface lsu_16_if;
   logic        mem_req_out;
   logic        mem_we_out;
   logic [15:0] mem_addr_out;
   logic [15:0] mem_wdata_out;
   logic        mem_ack_in;
   logic [15:0] mem_rdata_in;

   modport master (
      output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
      input  mem_ack_in, mem_rdata_in
   );

   modport slave (
      input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
      output mem_ack_in, mem_rdata_in
   );
endinterface

// File: rtl/lsu_16.sv
// lsu_16: load/store unit. Accepts one load or store from control and runs a
// single-outstanding req/ack transaction on the data-memory bus.
//   clk, rst_n   - rising-edge clock, synchronous active-low reset
//   start_in     - request, sampled only when idle
//   we_in        - 1 = store, 0 = load (captured with start_in)
//   addr_in      - word address (captured with start_in)
//   wdata_in     - store data (captured with start_in)
//   busy_out     - high whenever not idle
//   done_out     - one-cycle completion pulse
//   err_out      - one-cycle timeout pulse, coincident with done_out
//   ldata_out    - last load result, feeds the writeback mux
//   bus          - data-memory bus (master side)
// TIMEOUT bounds the cycles spent waiting for an acknowledge (1..255).
module lsu_16 #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_in,
   input  logic        we_in,
   input  logic [15:0] addr_in,
   input  logic [15:0] wdata_in,
   output logic        busy_out,
   output logic        done_out,
   output logic        err_out,
   output logic [15:0] ldata_out,
   lsu_16_if.master    bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   // Final counted REQ cycle; the counter never reaches TIMEOUT so 8 bits suffice.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] ldata_q, ldata_d;

   logic        timeout_hit;

   assign timeout_hit = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.mem_ack_in || timeout_hit) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output / datapath next values; every output is registered below
   always_comb begin
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ldata_d = ldata_q;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               we_d    = we_in;
               addr_d  = addr_in;
               wdata_d = wdata_in;
               req_d   = 1'b1;
               cnt_d   = '0;
            end
         end
         S_REQ: begin
            // Ack takes priority so an ack in the last counted cycle is a success
            if (bus.mem_ack_in) begin
               req_d  = 1'b0;
               done_d = 1'b1;
               if (!we_q) begin
                  ldata_d = bus.mem_rdata_in;
               end
            end else if (timeout_hit) begin
               req_d  = 1'b0;
               done_d = 1'b1;
               err_d  = 1'b1;
               if (!we_q) begin
                  ldata_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ldata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ldata_q <= ldata_d;
      end
   end

   assign busy_out          = (state_q != S_IDLE);
   assign done_out          = done_q;
   assign err_out           = err_q;
   assign ldata_out         = ldata_q;
   assign bus.mem_req_out   = req_q;
   assign bus.mem_we_out    = we_q;
   assign bus.mem_addr_out  = addr_q;
   assign bus.mem_wdata_out = wdata_q;

endmodule

// File: tb/tb_lsu_16.sv
module tb_lsu_16;

   localparam int unsigned TO = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_in;
   logic        we_in;
   logic [15:0] addr_in;
   logic [15:0] wdata_in;
   logic        busy_out;
   logic        done_out;
   logic        err_out;
   logic [15:0] ldata_out;

   lsu_16_if bus ();

   lsu_16 #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_in  (start_in),
      .we_in     (we_in),
      .addr_in   (addr_in),
      .wdata_in  (wdata_in),
      .busy_out  (busy_out),
      .done_out  (done_out),
      .err_out   (err_out),
      .ldata_out (ldata_out),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [15:0] model_ldata = '0;

   typedef struct {
      string       name;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int unsigned delay;        // ack in REQ cycle delay+1; >= TO means never
      logic        exp_err;
      logic [15:0] exp_ldata;
      int unsigned exp_cycles;   // cycles mem_req_out stays high
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a falling edge with the DUT idle; returns at a falling edge idle.
   task automatic run_txn(input string name, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata,
                          input int unsigned delay, input logic exp_err,
                          input logic [15:0] exp_ldata, input int unsigned exp_cycles);
      int unsigned n;
      start_in = 1'b1;
      we_in    = we;
      addr_in  = addr;
      wdata_in = wdata;
      @(negedge clk);
      start_in = 1'b0;
      we_in    = ~we;
      addr_in  = ~addr;
      wdata_in = ~wdata;
      n = 0;
      while (bus.mem_req_out === 1'b1 && n < 300) begin
         chk({name, " busy"}, 16'(busy_out), 16'd1);
         chk({name, " we"}, 16'(bus.mem_we_out), 16'(we));
         chk({name, " addr"}, bus.mem_addr_out, addr);
         chk({name, " wdata"}, bus.mem_wdata_out, wdata);
         if (n == delay) begin
            bus.mem_ack_in   = 1'b1;
            bus.mem_rdata_in = rdata;
         end else begin
            bus.mem_ack_in   = 1'b0;
            bus.mem_rdata_in = 16'($urandom);
         end
         n++;
         @(negedge clk);
      end
      bus.mem_ack_in = 1'b0;
      chk({name, " req_cycles"}, 16'(n), 16'(exp_cycles));
      chk({name, " done"}, 16'(done_out), 16'd1);
      chk({name, " err"}, 16'(err_out), 16'(exp_err));
      chk({name, " ldata"}, ldata_out, exp_ldata);
      @(negedge clk);
      chk({name, " done_clr"}, 16'(done_out), 16'd0);
      chk({name, " err_clr"}, 16'(err_out), 16'd0);
      chk({name, " idle"}, 16'(busy_out), 16'd0);
   endtask

   initial begin
      tbl[0] = '{"ld_imm",   1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0,  1'b0, 16'hBEEF, 1};
      tbl[1] = '{"st_dly",   1'b1, 16'h00FF, 16'h1234, 16'h9999, 3,  1'b0, 16'hBEEF, 4};
      tbl[2] = '{"ld_to",    1'b0, 16'h0100, 16'h0000, 16'h4444, 99, 1'b1, 16'h0000, 15};
      tbl[3] = '{"ld_last",  1'b0, 16'h0100, 16'h0000, 16'hCAFE, 14, 1'b0, 16'hCAFE, 15};
      tbl[4] = '{"st_to",    1'b1, 16'h0200, 16'h5555, 16'h1111, 99, 1'b1, 16'hCAFE, 15};
      tbl[5] = '{"ld_14",    1'b0, 16'h0300, 16'h0000, 16'h5A5A, 13, 1'b0, 16'h5A5A, 14};

      // Reset held with start asserted
      rst_n            = 1'b0;
      start_in         = 1'b1;
      we_in            = 1'b0;
      addr_in          = 16'h0040;
      wdata_in         = 16'h0000;
      bus.mem_ack_in   = 1'b0;
      bus.mem_rdata_in = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst busy", 16'(busy_out), 16'd0);
      chk("rst done", 16'(done_out), 16'd0);
      chk("rst err", 16'(err_out), 16'd0);
      chk("rst req", 16'(bus.mem_req_out), 16'd0);
      chk("rst we", 16'(bus.mem_we_out), 16'd0);
      chk("rst addr", bus.mem_addr_out, 16'd0);
      chk("rst wdata", bus.mem_wdata_out, 16'd0);
      chk("rst ldata", ldata_out, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst busy", 16'(busy_out), 16'd1);
      chk("post_rst req", 16'(bus.mem_req_out), 16'd1);
      chk("post_rst addr", bus.mem_addr_out, 16'h0040);
      start_in         = 1'b0;
      bus.mem_ack_in   = 1'b1;
      bus.mem_rdata_in = 16'h1111;
      @(negedge clk);
      bus.mem_ack_in = 1'b0;
      chk("post_rst done", 16'(done_out), 16'd1);
      chk("post_rst ldata", ldata_out, 16'h1111);
      @(negedge clk);
      chk("post_rst idle", 16'(busy_out), 16'd0);
      model_ldata = 16'h1111;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i].name, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                 tbl[i].delay, tbl[i].exp_err, tbl[i].exp_ldata, tbl[i].exp_cycles);
         model_ldata = tbl[i].exp_ldata;
      end

      // start_in during REQ and DONE is dropped; ack in IDLE does nothing
      start_in = 1'b1;
      we_in    = 1'b1;
      addr_in  = 16'h0010;
      wdata_in = 16'hA5A5;
      @(negedge clk);
      chk("busy req1", 16'(bus.mem_req_out), 16'd1);
      addr_in = 16'h0020;
      @(negedge clk);
      start_in = 1'b0;
      chk("busy req2", 16'(bus.mem_req_out), 16'd1);
      chk("busy addr_held", bus.mem_addr_out, 16'h0010);
      bus.mem_ack_in   = 1'b1;
      bus.mem_rdata_in = 16'h7777;
      @(negedge clk);
      bus.mem_ack_in = 1'b0;
      chk("busy done", 16'(done_out), 16'd1);
      chk("busy ldata", ldata_out, model_ldata);
      start_in = 1'b1;
      addr_in  = 16'h0030;
      @(negedge clk);
      start_in = 1'b0;
      chk("done_start idle", 16'(busy_out), 16'd0);
      chk("done_start req", 16'(bus.mem_req_out), 16'd0);
      bus.mem_ack_in   = 1'b1;
      bus.mem_rdata_in = 16'hFFFF;
      repeat (2) @(negedge clk);
      chk("idle_ack busy", 16'(busy_out), 16'd0);
      chk("idle_ack done", 16'(done_out), 16'd0);
      chk("idle_ack ldata", ldata_out, model_ldata);
      bus.mem_ack_in = 1'b0;

      // Randomized traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         logic        r_we;
         logic [15:0] r_addr, r_wdata, r_rdata, e_ldata;
         int unsigned r_delay, e_cycles;
         logic        e_err;
         r_we     = 1'($urandom);
         r_addr   = 16'($urandom);
         r_wdata  = 16'($urandom);
         r_rdata  = 16'($urandom);
         r_delay  = $urandom_range(0, 20);
         e_err    = (r_delay >= TO);
         e_cycles = e_err ? TO : r_delay + 1;
         e_ldata  = r_we ? model_ldata : (e_err ? 16'h0000 : r_rdata);
         run_txn("rand", r_we, r_addr, r_wdata, r_rdata, r_delay, e_err, e_ldata, e_cycles);
         model_ldata = e_ldata;
      end

      // Reset in the third REQ cycle
      start_in = 1'b1;
      we_in    = 1'b0;
      addr_in  = 16'h0050;
      @(negedge clk);
      start_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst req", 16'(bus.mem_req_out), 16'd0);
      chk("midrst done", 16'(done_out), 16'd0);
      chk("midrst err", 16'(err_out), 16'd0);
      chk("midrst busy", 16'(busy_out), 16'd0);
      chk("midrst ldata", ldata_out, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst no_done", 16'(done_out), 16'd0);
      model_ldata = '0;

      // Recovery after reset
      run_txn("recover", 1'b0, 16'h0060, 16'h0000, 16'h2468, 2, 1'b0, 16'h2468, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
